// File: rtl/byte_mask_pkg.sv
// Shared types and helpers for the byte-masked memory controller.
// Holds the access-size and FSM encodings, datapath geometry, and the
// lane-select function that yields the byte-enable mask plus legality
// for a size/offset pair.
package byte_mask_pkg;
  localparam int DATA_W    = 32;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef struct packed {
    logic                 legal;
    logic [NUM_LANES-1:0] mask;
  } lane_sel_t;

  // Misaligned halves/words and the reserved size are illegal; their mask
  // is still computed but never reaches the memory.
  function automatic lane_sel_t lane_sel(size_e sz, logic [1:0] off);
    lane_sel_t r;
    r = '0;
    case (sz)
      SZ_BYTE: begin r.legal = 1'b1;        r.mask = 4'b0001 << off; end
      SZ_HALF: begin r.legal = ~off[0];     r.mask = 4'b0011 << off; end
      SZ_WORD: begin r.legal = (off == 2'd0); r.mask = 4'b1111;      end
      default: begin r.legal = 1'b0;        r.mask = 4'b0000;        end
    endcase
    return r;
  endfunction
endpackage

// File: rtl/byte_lane_align.sv
// Combinational lane alignment for one access.
//   size_i/off_i : access size and byte offset
//   wdata_i      : LSB-aligned write data -> wdata_o lane-positioned
//   rdata_i      : raw memory word        -> rdata_o LSB-aligned, zero-extended
//   mask_o       : byte enables, legal_o : size/offset legality
module byte_lane_align
  import byte_mask_pkg::*;
(
  input  logic [1:0]           size_i,
  input  logic [1:0]           off_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [DATA_W-1:0]    rdata_i,
  output logic [NUM_LANES-1:0] mask_o,
  output logic                 legal_o,
  output logic [DATA_W-1:0]    wdata_o,
  output logic [DATA_W-1:0]    rdata_o
);
  lane_sel_t            sel;
  logic [DATA_W-1:0]    rd_sh;
  logic [NUM_LANES-1:0] keep;

  assign sel     = lane_sel(size_e'(size_i), off_i);
  assign mask_o  = sel.mask;
  assign legal_o = sel.legal;
  assign wdata_o = wdata_i << {off_i, 3'b000};
  assign rd_sh   = rdata_i >> {off_i, 3'b000};

  // Lanes kept after shifting down: width of the access, counted from lane 0.
  always_comb begin
    keep = '0;
    case (size_e'(size_i))
      SZ_BYTE: keep = 4'b0001;
      SZ_HALF: keep = 4'b0011;
      SZ_WORD: keep = 4'b1111;
      default: keep = 4'b0000;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign rdata_o[8*g +: 8] = rd_sh[8*g +: 8] & {8{keep[g]}};
  end
endmodule

// File: rtl/byte_masked_mem_ctrl.sv
// Single-outstanding command controller for a byte-masked word memory.
//   cmd_*  : command channel (valid/ready), byte address, size, write data
//   rsp_*  : response channel (valid/ready), read data, error flag
//   mem_*  : memory port, one-cycle enable pulse per legal access
// Illegal commands (reserved size, misaligned half/word) skip the memory
// and answer straight away with rsp_err.
module byte_masked_mem_ctrl
  import byte_mask_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic [ADDR_W+1:0]    cmd_addr,
  input  logic [1:0]           cmd_size,
  input  logic [DATA_W-1:0]    cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_data,
  output logic                 mem_enb,
  output logic                 mem_wr,
  output logic [NUM_LANES-1:0] mem_masked,
  input  logic [DATA_W-1:0]    mem_rdata
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_e              state_q, state_d;
  logic                wr_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]   maddr_q;
  logic [DATA_W-1:0]   mdata_q;

  logic                idle, issue, hs;
  logic [1:0]          al_size, al_off;
  logic [DATA_W-1:0]   al_wdata, al_wdata_sh, al_rdata;
  logic [NUM_LANES-1:0] al_mask;
  logic                al_legal;

  assign idle  = (state_q == IDLE);
  assign issue = (state_q == ISSUE);
  assign hs    = cmd_valid & cmd_ready;

  // In IDLE the aligner judges the offered command; afterwards it works on
  // the registered copy so the memory side never sees cmd_* changes.
  assign al_size  = idle ? cmd_size       : size_q;
  assign al_off   = idle ? cmd_addr[1:0]  : addr_q[1:0];
  assign al_wdata = idle ? cmd_wdata      : wdata_q;

  byte_lane_align u_align (
    .size_i  (al_size),
    .off_i   (al_off),
    .wdata_i (al_wdata),
    .rdata_i (mem_rdata),
    .mask_o  (al_mask),
    .legal_o (al_legal),
    .wdata_o (al_wdata_sh),
    .rdata_o (al_rdata)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (hs) begin
        rdata_d = '0;
        err_d   = ~al_legal;
        state_d = al_legal ? ISSUE : RESP;
      end
      ISSUE: begin
        if (wr_q) state_d = RESP;
        else begin
          state_d = RD_WAIT;
          cnt_d   = CW'(RD_LAT - 1);
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rdata_d = al_rdata;
          state_d = RESP;
        end else cnt_d = cnt_q - 1'b1;
      end
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      cnt_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      if (hs) begin
        wr_q    <= cmd_wr;
        addr_q  <= cmd_addr;
        size_q  <= cmd_size;
        wdata_q <= cmd_wdata;
      end
      // Keep the last driven address/data visible once the pulse ends.
      if (issue) begin
        maddr_q <= addr_q[ADDR_W+1:2];
        mdata_q <= al_wdata_sh;
      end
    end
  end

  assign cmd_ready  = idle & ~rst;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_err    = err_q;
  assign rsp_rdata  = rdata_q;
  assign mem_enb    = issue;
  assign mem_wr     = issue & wr_q;
  assign mem_masked = issue ? al_mask : '0;
  assign mem_addr   = issue ? addr_q[ADDR_W+1:2] : maddr_q;
  assign mem_data   = issue ? al_wdata_sh : mdata_q;
endmodule

// File: doc/byte_masked_mem_ctrl.md
BYTE_MASKED_MEM_CTRL -- requirements
Module: byte_masked_mem_ctrl

Interface
REQ-001 The block SHALL have the following parameters:
- ADDR_W, 3, memory word-address width.
- RD_LAT, 1, memory read latency in cycles from the enb/!wr sample edge to r_data valid.

REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W+2  byte address; [1:0] byte offset, [ADDR_W+1:2] word address.
- cmd_size  in  2  0 byte, 1 half, 2 word, 3 reserved.
- cmd_wdata  in  32  write data, LSB-aligned.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  32  read data, zero-extended and LSB-aligned; 0 for writes and errors.
- rsp_err  out  1  command rejected (misaligned or reserved size).
- mem_addr  out  ADDR_W  memory word address.
- mem_data  out  32  memory write data, lane-positioned.
- mem_enb  out  1  memory enable, one-cycle pulse per access.
- mem_wr  out  1  memory write strobe.
- mem_masked  out  4  byte enables; bit i gates data[8i+7:8i].
- mem_rdata  in  32  memory read data.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, RD_WAIT and RESP.
REQ-004 cmd_ready SHALL be 1 in IDLE only; a handshake registers the command and moves the FSM to ISSUE, or directly to RESP with rsp_err=1 when the command is illegal.
REQ-005 Illegal commands are: size 3; half with offset 1 or 3; word with offset not 0. Illegal commands SHALL never assert mem_enb.
REQ-006 In ISSUE, mem_enb SHALL be 1 for exactly that cycle, with mem_wr = cmd_wr and mem_addr = the word address.
REQ-007 mem_masked SHALL be: byte = 4'b0001<<off; half = 4'b0011<<off; word = 4'b1111. The same mask SHALL be driven for reads.
REQ-008 mem_data SHALL be cmd_wdata << (8*off), truncated to 32 bits.
REQ-009 When not in ISSUE, mem_enb, mem_wr and mem_masked SHALL be 0; mem_addr and mem_data SHALL hold their last values.
REQ-010 A write SHALL go ISSUE -> RESP. A read SHALL go ISSUE -> RD_WAIT and stay there RD_LAT cycles, capturing mem_rdata on the last RD_WAIT edge, then go to RESP.
REQ-011 Read extraction SHALL be (mem_rdata >> 8*off) masked to 8/16/32 bits by size, with upper bits zero.
REQ-012 Latency with RD_LAT=1 and handshake at edge T: mem_enb high in cycle T+1. rsp_valid first high in T+2 for a write and T+3 for a read. For an illegal command rsp_valid is first high in T+1.
REQ-013 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1. The FSM then returns to IDLE, with cmd_ready high the following cycle. At most one command is outstanding.
REQ-014 cmd_* inputs SHALL be ignored outside IDLE. mem_rdata SHALL be ignored outside RD_WAIT.

Reset
REQ-015 Assertion of rst SHALL immediately force:
- state = IDLE;
- cmd_ready = 0 while rst is high, 1 after release;
- rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
- mem_enb = 0, mem_wr = 0, mem_masked = 0, mem_addr = 0, mem_data = 0.
REQ-016 Reset mid-transaction SHALL abandon it without a response. A read in flight SHALL have its returning mem_rdata discarded.

Structure
REQ-017 Package byte_mask_pkg SHALL hold:
- size encoding enum;
- FSM state enum;
- DATA_W = 32 and NUM_LANES = 4;
- function computing the mask and legality from size/offset.
REQ-018 Combinational lane shift/mask/extract logic SHALL be in sub-module byte_lane_align, instantiated once. All state is in byte_masked_mem_ctrl.

Verification
REQ-019 The bench SHALL cover these directed scenarios, each paired with a behavioural memory model of latency RD_LAT:
- Byte write: addr 5'b00110, size 0, wdata 32'h000000AB -> mem_addr 1, mem_masked 4'b0100, mem_data 32'h00AB0000, mem_enb one cycle; rsp err 0 at T+2.
- Half read: after word 2 is written 32'hDEADBEEF, read addr 5'b01010, size 1 -> mem_masked 4'b1100; rsp_rdata 32'h0000DEAD at T+3.
- Illegal: word at addr 5'b00001, and size 3 -> mem_enb never high, rsp_err 1, rsp_rdata 0 at T+1.
- Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_rdata and rsp_err stable, cmd_ready 0; after release the next command is accepted.
- Reset during RD_WAIT -> all outputs 0 immediately, no rsp_valid; the next read returns correct data.
- Back-to-back random legal commands checked against a scoreboard -> all read data matches, with no unmasked byte altered.
